// File: rtl/ook_packet_tx.sv
// On-off-keying packet transmitter: serialises a latched payload as 3-chip pulse-width bits,
// repeats it with a fixed gap and pulses done. Define OOK_PREAMBLE_EN to prefix each repeat with a 1010.. preamble.
module ook_packet_tx #(
  parameter int MAX_BITS       = 64,
  parameter int LEN_W          = 7,
  parameter int REP_W          = 4,
  parameter int CHIP_DIV       = 4,
  parameter int GAP_CHIPS      = 10,
  parameter int PREAMBLE_CHIPS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [MAX_BITS-1:0] load_data,
  input  logic [LEN_W-1:0]    load_len,
  input  logic [REP_W-1:0]    load_repeats,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                ook
);

  localparam int PH_W    = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
  localparam int BIT_W   = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int CNT_MAX = (GAP_CHIPS > PREAMBLE_CHIPS) ? GAP_CHIPS : PREAMBLE_CHIPS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef OOK_PREAMBLE_EN
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_BITS, S_GAP, S_FIN} state_t;
  localparam state_t START_STATE = S_PRE;
`else
  typedef enum logic [1:0] {S_IDLE, S_BITS, S_GAP, S_FIN} state_t;
  localparam state_t START_STATE = S_BITS;
`endif

  state_t              state_reg;
  logic [PH_W-1:0]     phase_reg;
  logic [1:0]          chip_reg;
  logic [BIT_W-1:0]    bit_idx_reg;
  logic [BIT_W-1:0]    first_idx_reg;
  logic [REP_W-1:0]    rep_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [MAX_BITS-1:0] data_reg;
  logic                ook_reg;
  logic                busy_reg;
  logic                done_reg;

  logic [LEN_W-1:0]    len_clamped;
  logic [BIT_W-1:0]    first_idx;
  logic [REP_W-1:0]    rep_remaining;
  logic                accept;
  logic                chip_end;

  assign len_clamped   = (load_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : load_len;
  assign first_idx     = BIT_W'(len_clamped - 1'b1);
  assign rep_remaining = (load_repeats == '0) ? '0 : load_repeats - 1'b1;
  assign accept        = load_valid && !busy_reg && !abort;
  assign chip_end      = (phase_reg == PH_W'(CHIP_DIV - 1));

  assign load_ready = !busy_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign ook        = ook_reg;

  // ook_reg is loaded with the value of the chip the counters move into, so it
  // always lines up with the state/counter registers it is derived from.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      phase_reg     <= '0;
      chip_reg      <= '0;
      bit_idx_reg   <= '0;
      first_idx_reg <= '0;
      rep_reg       <= '0;
      cnt_reg       <= '0;
      data_reg      <= '0;
      ook_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else if (abort) begin
      state_reg <= S_IDLE;
      phase_reg <= '0;
      ook_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (busy_reg) begin
        phase_reg <= chip_end ? '0 : phase_reg + 1'b1;
      end
      case (state_reg)
        S_IDLE, S_FIN: begin
          state_reg <= S_IDLE;
          if (accept) begin
            data_reg      <= load_data;
            bit_idx_reg   <= first_idx;
            first_idx_reg <= first_idx;
            rep_reg       <= rep_remaining;
            phase_reg     <= '0;
            chip_reg      <= '0;
            cnt_reg       <= '0;
            if (len_clamped == '0) begin
              state_reg <= S_FIN;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= START_STATE;
              busy_reg  <= 1'b1;
              ook_reg   <= 1'b1;
            end
          end
        end
`ifdef OOK_PREAMBLE_EN
        S_PRE: begin
          if (chip_end) begin
            if (cnt_reg == CNT_W'(PREAMBLE_CHIPS - 1)) begin
              state_reg <= S_BITS;
              cnt_reg   <= '0;
              ook_reg   <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
              // Next chip index is cnt+1; even indices are high.
              ook_reg <= cnt_reg[0];
            end
          end
        end
`endif
        S_BITS: begin
          if (chip_end) begin
            if (chip_reg == 2'd2) begin
              chip_reg <= '0;
              if (bit_idx_reg == '0) begin
                state_reg <= S_GAP;
                cnt_reg   <= '0;
                ook_reg   <= 1'b0;
              end else begin
                bit_idx_reg <= bit_idx_reg - 1'b1;
                ook_reg     <= 1'b1;
              end
            end else begin
              chip_reg <= chip_reg + 1'b1;
              ook_reg  <= (chip_reg == 2'd0) ? data_reg[bit_idx_reg] : 1'b0;
            end
          end
        end
        S_GAP: begin
          if (chip_end) begin
            if (cnt_reg == CNT_W'(GAP_CHIPS - 1)) begin
              cnt_reg <= '0;
              if (rep_reg != '0) begin
                rep_reg     <= rep_reg - 1'b1;
                bit_idx_reg <= first_idx_reg;
                chip_reg    <= '0;
                state_reg   <= START_STATE;
                ook_reg     <= 1'b1;
              end else begin
                state_reg <= S_FIN;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                ook_reg   <= 1'b0;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ook_packet_tx.sv
// Randomised bench for ook_packet_tx: a chip-level waveform model built from the packet rules
// is compared cycle by cycle against ook/busy/done/load_ready.
`timescale 1ns/1ps
module tb_ook_packet_tx;
  localparam int MAX_BITS       = 64;
  localparam int LEN_W          = 7;
  localparam int REP_W          = 4;
  localparam int CHIP_DIV       = 4;
  localparam int GAP_CHIPS      = 10;
  localparam int PREAMBLE_CHIPS = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                load_valid;
  logic                load_ready;
  logic [MAX_BITS-1:0] load_data;
  logic [LEN_W-1:0]    load_len;
  logic [REP_W-1:0]    load_repeats;
  logic                abort;
  logic                busy;
  logic                done;
  logic                ook;

  int tests = 0;
  int fails = 0;
  bit exp_q[$];

  always #50 clk = ~clk;

  ook_packet_tx #(
    .MAX_BITS(MAX_BITS), .LEN_W(LEN_W), .REP_W(REP_W), .CHIP_DIV(CHIP_DIV),
    .GAP_CHIPS(GAP_CHIPS), .PREAMBLE_CHIPS(PREAMBLE_CHIPS)
  ) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len), .load_repeats(load_repeats),
    .abort(abort), .busy(busy), .done(done), .ook(ook)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic expect_state(input string tag, input int c, input bit e_ook, input bit e_busy,
                              input bit e_done);
    chk($sformatf("%s ook c%0d", tag, c), 64'(ook), 64'(e_ook));
    chk($sformatf("%s busy c%0d", tag, c), 64'(busy), 64'(e_busy));
    chk($sformatf("%s done c%0d", tag, c), 64'(done), 64'(e_done));
    chk($sformatf("%s ready c%0d", tag, c), 64'(load_ready), 64'(!e_busy));
  endtask

  function automatic void push_chip(input bit v);
    for (int k = 0; k < CHIP_DIV; k++) exp_q.push_back(v);
  endfunction

  // Expected ook level for every busy cycle of one transfer.
  function automatic void build(input logic [63:0] d, input int len, input int rep);
    int n = (len > MAX_BITS) ? MAX_BITS : len;
    int r = (rep == 0) ? 1 : rep;
    exp_q.delete();
    if (n == 0) return;
    for (int rr = 0; rr < r; rr++) begin
`ifdef OOK_PREAMBLE_EN
      for (int p = 0; p < PREAMBLE_CHIPS; p++) push_chip(p % 2 == 0);
`endif
      for (int i = n - 1; i >= 0; i--) begin
        push_chip(1'b1);
        push_chip(d[i]);
        push_chip(1'b0);
      end
      for (int g = 0; g < GAP_CHIPS; g++) push_chip(1'b0);
    end
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle with load_valid low.
  task automatic run_tx(input logic [63:0] d, input int len, input int rep, input bit hold);
    int t;
    load_valid   = 1'b1;
    load_data    = d;
    load_len     = LEN_W'(len);
    load_repeats = REP_W'(rep);
    build(d, len, rep);
    t = exp_q.size();
    @(posedge clk);
    for (int c = 1; c <= t + 1; c++) begin
      @(negedge clk);
      if (c <= t) expect_state("tx", c, exp_q[c-1], 1'b1, 1'b0);
      else        expect_state("tx", c, 1'b0, 1'b0, 1'b1);
      if (hold && c <= t) begin
        load_valid   = 1'b1;
        load_data    = {$urandom, $urandom};
        load_len     = LEN_W'($urandom_range(0, 127));
        load_repeats = REP_W'($urandom_range(0, 15));
      end else begin
        load_valid = 1'b0;
      end
    end
    $display("[TB] tx len=%0d rep=%0d hold=%0b cycles=%0d data=%0h", len, rep, hold, t, d);
  endtask

  initial begin
    reset        = 1'b1;
    load_valid   = 1'b0;
    load_data    = '0;
    load_len     = '0;
    load_repeats = '0;
    abort        = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      expect_state("reset", c, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    $display("[TB] reset held 3 cycles");

    run_tx(64'b101, 3, 1, 1'b0);
    run_tx(64'b101, 3, 3, 1'b0);
    run_tx(64'b101, 3, 0, 1'b0);
    run_tx(64'b101, 3, 1, 1'b1);
    run_tx(64'h0, 0, 1, 1'b0);
    run_tx({$urandom, $urandom}, 100, 1, 1'b0);

    // Abort at cycle 20 of the single-packet case, reload at cycle 22.
    load_valid = 1'b1; load_data = 64'b101; load_len = 7'd3; load_repeats = 4'd1;
    build(64'b101, 3, 1);
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      expect_state("abort", c, exp_q[c-1], 1'b1, 1'b0);
      load_valid = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    expect_state("abort", 21, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expect_state("abort", 22, 1'b0, 1'b0, 1'b0);
    $display("[TB] abort at cycle 20");
    run_tx(64'b101, 3, 1, 1'b0);

    // Abort and load together while idle: the load must be dropped.
    abort = 1'b1; load_valid = 1'b1; load_len = 7'd5; load_data = 64'h1f;
    @(negedge clk);
    abort = 1'b0; load_valid = 1'b0;
    expect_state("abort_load", 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expect_state("abort_load", 2, 1'b0, 1'b0, 1'b0);
    $display("[TB] abort with simultaneous load");

    // Reset in the middle of a transfer.
    load_valid = 1'b1; load_data = 64'hff; load_len = 7'd8; load_repeats = 4'd2;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      load_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_state("midreset", 11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expect_state("midreset", 12, 1'b0, 1'b0, 1'b0);
    $display("[TB] reset mid-transfer");
    run_tx(64'b110, 3, 2, 1'b0);

    for (int n = 0; n < 25; n++) begin
      int len;
      len = $urandom_range(0, 16);
      if ($urandom_range(0, 7) == 0) len = $urandom_range(60, 70);
      run_tx({$urandom, $urandom}, len, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
